ram_port_arbiter: RTL

Shares the byteblast8 single-port 32x8 data/program RAM between the CPU core (fetch/decode/store path) and a debug/loader port. Grants at most one RAM access per clk cycle, stalls the losing requester and prevents debug starvation. Supports an exclusive debug lock that freezes core RAM access for program download or inspection. Sits between the core's address mux / accumulator write path and the ram instance.

---
 rtl/ram_port_arbiter_pkg.sv | 16 +
 rtl/ram_port_arbiter_if.sv | 52 +++++
 rtl/arb_wait_cnt.sv | 42 ++++
 rtl/ram_port_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the byteblast8 RAM port arbiter: bus width defaults,
// wait counter width and the arbiter state encoding.
package ram_port_arbiter_pkg;

    localparam int unsigned ADDRESS_BITS_DEF = 5;
    localparam int unsigned DATA_BITS_DEF    = 8;

    // Wide enough for WAIT_MAX up to 15.
    localparam int unsigned CNT_BITS = 4;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the core, the debug/loader port, the arbiter and the RAM.
// slave  : arbiter view (takes requests and ram_rdata, drives grants and ram_*)
// master : requester/RAM side view (drives requests and ram_rdata)
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = ADDRESS_BITS_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
);
    logic                    core_req;
    logic                    core_we;
    logic [ADDRESS_BITS-1:0] core_addr;
    logic [DATA_BITS-1:0]    core_wdata;
    logic                    core_gnt;
    logic                    core_stall;
    logic                    core_rvalid;

    logic                    dbg_req;
    logic                    dbg_we;
    logic [ADDRESS_BITS-1:0] dbg_addr;
    logic [DATA_BITS-1:0]    dbg_wdata;
    logic                    dbg_lock;
    logic                    dbg_gnt;
    logic                    dbg_rvalid;

    logic                    locked;
    logic [DATA_BITS-1:0]    rdata;

    logic                    ram_we;
    logic [ADDRESS_BITS-1:0] ram_addr;
    logic [DATA_BITS-1:0]    ram_wdata;
    logic [DATA_BITS-1:0]    ram_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  ram_rdata,
        output core_gnt, core_stall, core_rvalid,
        output dbg_gnt, dbg_rvalid, locked, rdata,
        output ram_we, ram_addr, ram_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output ram_rdata,
        input  core_gnt, core_stall, core_rvalid,
        input  dbg_gnt, dbg_rvalid, locked, rdata,
        input  ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/arb_wait_cnt.sv
// Saturating debug wait counter.
// Ports: clk, reset (async active-low), inc (count one lost cycle),
//        clr (clear, has priority), sat (registered: count == WAIT_MAX).
module arb_wait_cnt
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(WAIT_MAX);

    logic [CNT_BITS-1:0] count;
    logic [CNT_BITS-1:0] count_nxt;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (inc && (count != MAX_CNT)) begin
            count_nxt = count + CNT_BITS'(1);
        end
    end

    // Count and its saturation flag are registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= count_nxt;
            sat   <= (count_nxt == MAX_CNT);
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port 32x8 RAM between the CPU core and the debug/loader
// port: at most one access per cycle, core priority with debug anti-starvation
// after WAIT_MAX lost cycles, and an exclusive debug lock.
// Ports: clk, reset (async active-low), bus (slave modport carrying core/debug
//        request+grant signals, locked, rdata and the ram_* interface).
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = ADDRESS_BITS_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
    parameter int unsigned WAIT_MAX     = 4
) (
    input  logic                clk,
    input  logic                reset,
    ram_port_arbiter_if.slave   bus
);

    arb_state_e              state;
    logic                    core_win;
    logic                    dbg_win;
    logic                    wait_sat;
    logic                    wait_inc;
    logic                    wait_clr;
    logic                    core_rvalid_q;
    logic                    dbg_rvalid_q;
    logic                    ram_we_sel;
    logic [ADDRESS_BITS-1:0] ram_addr_sel;
    logic [DATA_BITS-1:0]    ram_wdata_sel;

    arb_wait_cnt #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .sat   (wait_sat)
    );

    // Debug lost this cycle -> count; any debug grant or the lock clears it.
    assign wait_inc = bus.dbg_req & ~dbg_win;
    assign wait_clr = dbg_win | (state == ST_LOCKED);

    // Grant decision; reset is folded in so nothing is granted while held.
    always_comb begin
        core_win = 1'b0;
        dbg_win  = 1'b0;
        if (reset) begin
            if (state == ST_LOCKED) begin
                dbg_win = bus.dbg_req;
            end else if (bus.dbg_req && (!bus.core_req || wait_sat)) begin
                dbg_win = 1'b1;
            end else begin
                core_win = bus.core_req;
            end
        end
    end

    // Winner drives the RAM; idle bus is all zeros.
    always_comb begin
        ram_we_sel    = 1'b0;
        ram_addr_sel  = '0;
        ram_wdata_sel = '0;
        if (core_win) begin
            ram_we_sel    = bus.core_we;
            ram_addr_sel  = bus.core_addr;
            ram_wdata_sel = bus.core_wdata;
        end else if (dbg_win) begin
            ram_we_sel    = bus.dbg_we;
            ram_addr_sel  = bus.dbg_addr;
            ram_wdata_sel = bus.dbg_wdata;
        end
    end

    // Lock state and read-valid flags; a read grant returns data next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_NORMAL;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
        end else begin
            state         <= bus.dbg_lock ? ST_LOCKED : ST_NORMAL;
            core_rvalid_q <= core_win & ~bus.core_we;
            dbg_rvalid_q  <= dbg_win & ~bus.dbg_we;
        end
    end

    assign bus.core_gnt    = core_win;
    assign bus.core_stall  = bus.core_req & ~core_win;
    assign bus.core_rvalid = core_rvalid_q;
    assign bus.dbg_gnt     = dbg_win;
    assign bus.dbg_rvalid  = dbg_rvalid_q;
    assign bus.locked      = (state == ST_LOCKED);
    assign bus.rdata       = bus.ram_rdata;
    assign bus.ram_we      = ram_we_sel;
    assign bus.ram_addr    = ram_addr_sel;
    assign bus.ram_wdata   = ram_wdata_sel;

endmodule
